// File: rtl/round_countdown.sv
// Down-counting round timer: loads SECONDS on start, decrements once per
// TICKS_PER_SEC clock cycles, and presents the remaining time as two BCD
// digits. Supports pause and flags expiry so the game FSM can end a round.
module round_countdown #(
    parameter int TICKS_PER_SEC = 781250,
    parameter int SECONDS       = 60,
    parameter int PW            = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Reload digits are elaboration-time constants; the binary value of the
    // remaining time is never formed.
    localparam logic [3:0]    RELOAD_TENS = 4'(SECONDS / 10);
    localparam logic [3:0]    RELOAD_ONES = 4'(SECONDS % 10);
    localparam logic [PW-1:0] TICK_LAST   = PW'(TICKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          expired_q, expired_d;

    // Next-state, prescaler and BCD digit update.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        expired_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end
            end

            ST_RUN: begin
                // pause takes priority over a tick on the same edge, so the
                // tick is deferred until after resume.
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_PAUSED: begin
                // Resume edge only changes state; counting restarts on the
                // edge after it.
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end
            end

            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                tens_d  = RELOAD_TENS;
                ones_d  = RELOAD_ONES;
            end
        endcase

        // One-cycle pulse on entry into DONE.
        expired_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State and datapath registers with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tens_q    <= RELOAD_TENS;
            ones_q    <= RELOAD_ONES;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            expired_q <= expired_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign expired = expired_q;

endmodule

// File: tb/tb_round_countdown.sv
// Directed bench for round_countdown with TICKS_PER_SEC=4. Instance a uses
// SECONDS=3, instance b uses SECONDS=12 for the BCD borrow path.
module tb_round_countdown;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, pause_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic       running_a, done_a, expired_a;
    logic       running_b, done_b, expired_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_countdown #(.TICKS_PER_SEC(4), .SECONDS(3), .PW(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pause(pause_a),
        .tens(tens_a), .ones(ones_a), .running(running_a),
        .done(done_a), .expired(expired_a)
    );

    round_countdown #(.TICKS_PER_SEC(4), .SECONDS(12), .PW(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pause(1'b0),
        .tens(tens_b), .ones(ones_b), .running(running_b),
        .done(done_b), .expired(expired_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input int t, input int o,
                           input int r, input int d, input int e);
        check({tag, "_tens"}, int'(tens_a), t);
        check({tag, "_ones"}, int'(ones_a), o);
        check({tag, "_running"}, int'(running_a), r);
        check({tag, "_done"}, int'(done_a), d);
        check({tag, "_expired"}, int'(expired_a), e);
    endtask

    // Full 3-second run from a start pulse already sampled at E0 (we are just
    // after E0 on entry).
    task automatic run_three(input string tag);
        check_a({tag, "_e0"}, 0, 3, 1, 0, 0);
        ticks(3);
        check_a({tag, "_e3"}, 0, 3, 1, 0, 0);
        ticks(1);
        check_a({tag, "_e4"}, 0, 2, 1, 0, 0);
        ticks(4);
        check_a({tag, "_e8"}, 0, 1, 1, 0, 0);
        ticks(3);
        check_a({tag, "_e11"}, 0, 1, 1, 0, 0);
        ticks(1);
        check_a({tag, "_e12"}, 0, 0, 0, 1, 1);
    endtask

    initial begin
        // Reset, then idle 10 cycles
        ticks(2);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ticks(1);
            check_a("idle", 0, 3, 0, 0, 0);
        end
        $display("reset/idle: digits 03, outputs low for 10 cycles");

        // Plain countdown
        start_a = 1'b1;
        ticks(1);
        start_a = 1'b0;
        run_three("run");
        ticks(1);
        check_a("run_e13", 0, 0, 0, 1, 0);
        $display("countdown: 3->0 at E0+4/8/12, expired one cycle");

        // Restart from DONE, pause sampled high at E0+2..E0+5
        start_a = 1'b1;
        ticks(1);
        start_a = 1'b0;
        check_a("pz_e0", 0, 3, 1, 0, 0);
        ticks(1);
        pause_a = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            ticks(1);
            check_a("pz_frozen", 0, 3, 0, 0, 0);
        end
        pause_a = 1'b0;
        ticks(1);
        check_a("pz_e6", 0, 3, 1, 0, 0);
        ticks(2);
        check_a("pz_e8", 0, 3, 1, 0, 0);
        ticks(1);
        check_a("pz_e9", 0, 2, 1, 0, 0);
        ticks(4);
        check_a("pz_e13", 0, 1, 1, 0, 0);
        ticks(3);
        check_a("pz_e16", 0, 1, 1, 0, 0);
        ticks(1);
        check_a("pz_e17", 0, 0, 0, 1, 1);
        $display("pause: first decrement E0+9, DONE E0+17");

        // BCD borrow on SECONDS=12
        start_b = 1'b1;
        ticks(1);
        start_b = 1'b0;
        check("bcd_e0_tens", int'(tens_b), 1);
        check("bcd_e0_ones", int'(ones_b), 2);
        for (int c = 1; c <= 48; c++) begin
            ticks(1);
            check("bcd_tens_valid", int'(tens_b <= 4'd9), 1);
            check("bcd_ones_valid", int'(ones_b <= 4'd9), 1);
            if (c % 4 == 0) begin
                check("bcd_tens", int'(tens_b), (12 - c / 4) / 10);
                check("bcd_ones", int'(ones_b), (12 - c / 4) % 10);
            end
        end
        check("bcd_done", int'(done_b), 1);
        check("bcd_expired", int'(expired_b), 1);
        $display("bcd: 12 down to 00 with borrow 10->09");

        // Held start ignored in RUN, released after DONE, then fresh pulse
        start_a = 1'b1;
        ticks(1);
        run_three("held");
        start_a = 1'b0;
        ticks(1);
        check_a("held_stay", 0, 0, 0, 1, 0);
        start_a = 1'b1;
        ticks(1);
        start_a = 1'b0;
        run_three("again");
        $display("held start: ignored in RUN, fresh pulse restarts with same timing");

        // Reset mid-run at E0+6
        ticks(1);
        start_a = 1'b1;
        ticks(1);
        start_a = 1'b0;
        ticks(5);
        check_a("rst_e5", 0, 2, 1, 0, 0);
        reset = 1'b1;
        ticks(1);
        check_a("rst_e6", 0, 3, 0, 0, 0);
        reset = 1'b0;
        ticks(2);
        check_a("rst_idle", 0, 3, 0, 0, 0);
        $display("reset in RUN: back to IDLE with 03");

        // start & pause together in IDLE
        start_a = 1'b1;
        pause_a = 1'b1;
        ticks(1);
        start_a = 1'b0;
        check_a("sp_run", 0, 3, 1, 0, 0);
        ticks(1);
        check_a("sp_paused", 0, 3, 0, 0, 0);
        ticks(6);
        check_a("sp_hold", 0, 3, 0, 0, 0);
        pause_a = 1'b0;
        ticks(1);
        check_a("sp_resume", 0, 3, 1, 0, 0);
        $display("start&pause in IDLE: RUN then PAUSED, 03 held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
